// File: rtl/native_regbank_pkg.sv
// Shared constants for native_regbank: register offsets, ID default and unmapped read value.
// Latency: n/a (package only).
// Backpressure: n/a.
package native_regbank_pkg;

    localparam logic [7:0] OFF_ID           = 8'h00;
    localparam logic [7:0] OFF_CTRL         = 8'h04;
    localparam logic [7:0] OFF_STATUS       = 8'h08;
    localparam logic [7:0] OFF_IRQ_MASK     = 8'h0C;
    localparam logic [7:0] OFF_WCNT         = 8'h10;
    localparam logic [7:0] OFF_SCRATCH_BASE = 8'h20;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hC0DE_0001;
    localparam logic [31:0] UNMAPPED_RDATA   = 32'h0000_0000;

    // The bank decodes 32-bit words, so byte offsets collapse to a 6-bit word index.
    function automatic logic [5:0] word_off(input logic [7:0] byte_off);
        return 6'(byte_off >> 2);
    endfunction

endpackage

// File: rtl/w1c_status_reg.sv
// Per-bit sticky status register: set by event pulses, cleared by write-one-to-clear.
// Latency: 1 cycle from set/clear to status_o; set wins over a same-cycle clear.
// Backpressure: none, every pulse is captured.
module w1c_status_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] set_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] status_o
);

    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_d;

    assign status_d = (status_q & ~clr_i) | set_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status_o = status_q;

endmodule

// File: rtl/native_regbank.sv
// Register bank on a native strobe bus: ID, CTRL, STATUS(W1C), IRQ_MASK, optional WCNT (NATIVE_REGBANK_WCNT_EN), SCRATCH.
// Latency: writes take effect on the WEN edge; RVALID/RDATA one cycle after REN; IRQ one cycle after STATUS/MASK.
// Backpressure: none, a strobe is accepted every cycle.
module native_regbank
    import native_regbank_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    EVENT_WIDTH = 8,
    parameter int                    NUM_SCRATCH = 4,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
    input  logic                   AXI_ACLK,
    input  logic                   AXI_ARESETN,
    input  logic                   WEN,
    input  logic [ADDR_WIDTH-1:0]  WADDR,
    input  logic [DATA_WIDTH-1:0]  WDATA,
    input  logic                   WACK,
    input  logic                   REN,
    input  logic [ADDR_WIDTH-1:0]  RADDR,
    output logic [DATA_WIDTH-1:0]  RDATA,
    output logic                   RVALID,
    input  logic [EVENT_WIDTH-1:0] EVENT,
    output logic [DATA_WIDTH-1:0]  CTRL,
    output logic                   IRQ
);

    localparam logic [5:0] W_ID     = word_off(OFF_ID);
    localparam logic [5:0] W_CTRL   = word_off(OFF_CTRL);
    localparam logic [5:0] W_STATUS = word_off(OFF_STATUS);
    localparam logic [5:0] W_MASK   = word_off(OFF_IRQ_MASK);
    localparam logic [5:0] W_WCNT   = word_off(OFF_WCNT);
    localparam logic [5:0] W_SCR    = word_off(OFF_SCRATCH_BASE);

    logic [5:0]             woff;
    logic [5:0]             roff;
    logic                   wr_ctrl;
    logic                   wr_status;
    logic                   wr_mask;
    logic                   wr_wcnt;
    logic [NUM_SCRATCH-1:0] wr_scr;

    logic [DATA_WIDTH-1:0]  ctrl_q;
    logic [EVENT_WIDTH-1:0] mask_q;
    logic [EVENT_WIDTH-1:0] status_q;
    logic [EVENT_WIDTH-1:0] status_clr;
    logic [DATA_WIDTH-1:0]  scratch_q [NUM_SCRATCH];
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic [DATA_WIDTH-1:0]  rdata_d;
    logic                   rvalid_q;
    logic                   irq_q;

    // Bits [1:0] and everything above bit 7 drop out here, so upper addresses alias.
    assign woff = 6'(WADDR >> 2);
    assign roff = 6'(RADDR >> 2);

    always_comb begin
        wr_ctrl   = WEN && (woff == W_CTRL);
        wr_status = WEN && (woff == W_STATUS);
        wr_mask   = WEN && (woff == W_MASK);
        wr_wcnt   = WEN && (woff == W_WCNT);
        wr_scr    = '0;
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            wr_scr[i] = WEN && (woff == W_SCR + 6'(i));
        end
    end

    assign status_clr = wr_status ? WDATA[EVENT_WIDTH-1:0] : '0;

    w1c_status_reg #(
        .WIDTH(EVENT_WIDTH)
    ) u_status (
        .clk_i   (AXI_ACLK),
        .rst_ni  (AXI_ARESETN),
        .set_i   (EVENT),
        .clr_i   (status_clr),
        .status_o(status_q)
    );

`ifdef NATIVE_REGBANK_WCNT_EN
    logic [DATA_WIDTH-1:0] wcnt_q;
    logic [DATA_WIDTH-1:0] wcnt_d;

    // A software clear beats a coincident completion pulse.
    always_comb begin
        wcnt_d = wcnt_q;
        if (wr_wcnt) begin
            wcnt_d = '0;
        end else if (WACK) begin
            wcnt_d = wcnt_q + 1'b1;
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end
`else
    logic unused_wcnt;
    assign unused_wcnt = WACK ^ wr_wcnt;
`endif

    always_comb begin
        rdata_d = UNMAPPED_RDATA;
        case (roff)
            W_ID:     rdata_d = ID_VALUE;
            W_CTRL:   rdata_d = ctrl_q;
            W_STATUS: rdata_d = DATA_WIDTH'(status_q);
            W_MASK:   rdata_d = DATA_WIDTH'(mask_q);
`ifdef NATIVE_REGBANK_WCNT_EN
            W_WCNT:   rdata_d = wcnt_q;
`endif
            default:  rdata_d = UNMAPPED_RDATA;
        endcase
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (roff == W_SCR + 6'(i)) begin
                rdata_d = scratch_q[i];
            end
        end
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            ctrl_q   <= '0;
            mask_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            irq_q    <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            if (wr_ctrl) ctrl_q <= WDATA;
            if (wr_mask) mask_q <= WDATA[EVENT_WIDTH-1:0];
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (wr_scr[i]) scratch_q[i] <= WDATA;
            end
            rvalid_q <= REN;
            if (REN) rdata_q <= rdata_d;
            irq_q <= |(status_q & mask_q);
        end
    end

    assign RDATA  = rdata_q;
    assign RVALID = rvalid_q;
    assign CTRL   = ctrl_q;
    assign IRQ    = irq_q;

endmodule

// File: doc/native_regbank.md
NATIVE_REGBANK -- requirements
Module: native_regbank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register and data bus width, 32 only.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: native address width.
REQ-003 SHALL have parameter EVENT_WIDTH, default 8: number of STATUS event bits, 1..DATA_WIDTH.
REQ-004 SHALL have parameter NUM_SCRATCH, default 4: number of scratch registers, 1..8.
REQ-005 SHALL have parameter ID_VALUE, default 32'hC0DE_0001: constant returned by the ID register.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port AXI_ACLK  input  1  clock.
REQ-008 SHALL have port AXI_ARESETN  input  1  asynchronous active-low reset.
REQ-009 SHALL have port WEN  input  1  single-cycle write strobe.
REQ-010 SHALL have port WADDR  input  ADDR_WIDTH  write byte address.
REQ-011 SHALL have port WDATA  input  DATA_WIDTH  write data.
REQ-012 SHALL have port WACK  input  1  write-completion pulse, issued after the AXI response handshake.
REQ-013 SHALL have port REN  input  1  single-cycle read strobe.
REQ-014 SHALL have port RADDR  input  ADDR_WIDTH  read byte address.
REQ-015 SHALL have port RDATA  output  DATA_WIDTH  read data.
REQ-016 SHALL have port RVALID  output  1  read-data-valid pulse.
REQ-017 SHALL have port EVENT  input  EVENT_WIDTH  per-bit single-cycle event pulses.
REQ-018 SHALL have port CTRL  output  DATA_WIDTH  current CTRL register value.
REQ-019 SHALL have port IRQ  output  1  registered interrupt, level.

Function
REQ-020 SHALL decode on address bits [7:2] only; bits [1:0] and [ADDR_WIDTH-1:8] are ignored, so upper addresses alias.
REQ-021 SHALL implement this map: 0x00 ID (RO); 0x04 CTRL (RW); 0x08 STATUS (W1C); 0x0C IRQ_MASK (RW, low EVENT_WIDTH bits); 0x10 WCNT; 0x20+4*i SCRATCH[i] (RW), i < NUM_SCRATCH.
REQ-022 SHALL apply a write on the AXI_ACLK edge where WEN=1; writes to RO or unmapped offsets are ignored.
REQ-023 SHALL assert RVALID exactly one cycle after each REN=1, for one cycle, with RDATA valid in that cycle.
REQ-024 SHALL accept REN on consecutive cycles, producing back-to-back RVALID pulses.
REQ-025 SHALL hold RDATA at its last value while RVALID=0.
REQ-026 SHALL return 0 for reads of unmapped offsets, including scratch indices >= NUM_SCRATCH.
REQ-027 SHALL set STATUS[k] on any cycle with EVENT[k]=1, and clear it on a write with WDATA[k]=1.
REQ-028 SHALL let set win when an event and a W1C hit the same STATUS bit in the same cycle; the bit stays 1.
REQ-029 SHALL return pre-edge values when REN and WEN (or an event) target the same register in the same cycle.
REQ-030 SHALL drive IRQ one cycle after the fact as the registered OR of (STATUS & IRQ_MASK).
REQ-031 SHALL read STATUS and IRQ_MASK with bits above EVENT_WIDTH as 0.

Reset
REQ-032 SHALL, on AXI_ARESETN=0 and asynchronously, clear CTRL, STATUS, IRQ_MASK, WCNT, all SCRATCH, RDATA, RVALID and IRQ to 0.
REQ-033 SHALL discard a read in flight when reset is asserted mid-operation: no RVALID after reset release.
REQ-034 SHALL ignore WEN, REN, WACK and EVENT while reset is asserted.

Configuration
REQ-035 SHALL compile in, when macro NATIVE_REGBANK_WCNT_EN is defined, WCNT as a DATA_WIDTH counter with these rules:
- increments on each WACK pulse;
- wraps from all-ones to 0;
- any write to 0x10 clears it;
- when a clear and WACK coincide, the clear wins and WCNT becomes 0.
REQ-036 SHALL, without NATIVE_REGBANK_WCNT_EN, leave no counter logic; offset 0x10 reads 0, writes are ignored and WACK is unused.

Structure
REQ-037 SHALL place register offset constants, the scratch base offset, the ID_VALUE default and the unmapped-read value in the shared package native_regbank_pkg.
REQ-038 SHALL implement the STATUS register as the sub-module w1c_status_reg (per-bit set/W1C, set priority, async reset).

Verification
REQ-039 SHALL cover this scenario: reset, then REN at RADDR=0x00 -> RVALID one cycle later with RDATA=0xC0DE0001.
REQ-040 SHALL cover this scenario: WEN at WADDR=0x24 with WDATA=0xA5A5A5A5, then REN at 0x24 -> RDATA=0xA5A5A5A5; REN at 0x40 -> RDATA=0.
REQ-041 SHALL cover this scenario: EVENT=0x05, IRQ_MASK=0x04 -> STATUS reads 0x05 and IRQ=1; then write 0x04 to 0x08 with EVENT[2]=1 in the same cycle -> STATUS stays 0x05.
REQ-042 SHALL cover this scenario: REN on 3 consecutive cycles at 0x04, 0x08, 0x20 -> 3 consecutive RVALID pulses with matching data.
REQ-043 SHALL cover this scenario: with NATIVE_REGBANK_WCNT_EN, 3 WACK pulses -> WCNT=3; a write to 0x10 coinciding with WACK -> WCNT=0.
REQ-044 SHALL cover this scenario: AXI_ARESETN deasserted the cycle after REN -> no RVALID, and all registers read 0 except ID.
